// File: rtl/matrix_mul_sched.sv
// -----------------------------------------------------------------------------
// matrix_mul_sched
//
// In-order command scheduler for the matrix multiply datapath. Commands are
// queued in a small FIFO. Each command is issued to the datapath as a
// single-cycle mm_en pulse. The datapath operand controls (type, mode, address)
// stay stable until the operation completes. Matrix completions are reported
// as a mat_done pulse. Transformed vertices are returned through a
// valid/ready output register.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake (cmd_ready = FIFO not full)
//   cmd_type/mode/addr      1 = matrix op, 0 = vertex; target matrix; operand B
//   mm_en                   one-cycle start pulse to the datapath
//   mm_mul_type/mode/addr   operation controls held for the datapath
//   mm_write_en, mm_vector  datapath matrix write-back strobe, vector result
//   busy                    operation in flight or commands queued
//   mat_done, mat_done_mode matrix completion pulse and its target matrix
//   vout_valid/ready/data   transformed vertex output register
//   err_timeout             sticky: a matrix op never signalled write-back
// -----------------------------------------------------------------------------
module matrix_mul_sched #(
  parameter int DEPTH       = 4,
  parameter int VTX_CYCLES  = 8,
  parameter int MAT_TIMEOUT = 31
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_type,
  input  logic         cmd_mode,
  input  logic [31:0]  cmd_addr,
  output logic         mm_en,
  output logic         mm_mul_type,
  output logic         mm_mode,
  output logic [31:0]  mm_addr,
  input  logic         mm_write_en,
  input  logic [127:0] mm_vector,
  output logic         busy,
  output logic         mat_done,
  output logic         mat_done_mode,
  output logic         vout_valid,
  input  logic         vout_ready,
  output logic [127:0] vout_data,
  output logic         err_timeout
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CNT_MAX = (VTX_CYCLES > MAT_TIMEOUT) ? VTX_CYCLES : MAT_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MAT_RUN = 2'd1,
    S_VTX_RUN = 2'd2
  } state_e;

  typedef struct packed {
    logic        is_mat;
    logic        mode;
    logic [31:0] addr;
  } cmd_t;

  // ---------------------------------------------------------------------------
  // Command FIFO: pointers carry one extra wrap bit to tell full from empty.
  // ---------------------------------------------------------------------------
  cmd_t        mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        fifo_empty, fifo_full;
  logic        push, pop;
  cmd_t        head, cmd_in;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && cmd_ready;
  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign cmd_in     = '{is_mat: cmd_type, mode: cmd_mode, addr: cmd_addr};

  // NOTE: the FIFO storage has no reset; the pointers alone define which
  // entries are live, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= cmd_in;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  // ---------------------------------------------------------------------------
  // Scheduler state
  // ---------------------------------------------------------------------------
  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           mm_mul_type_q, mm_mul_type_d;
  logic           mm_mode_q, mm_mode_d;
  logic [31:0]    mm_addr_q, mm_addr_d;
  logic           mat_done_q, mat_done_d;
  logic           mat_done_mode_q, mat_done_mode_d;
  logic           vout_valid_q, vout_valid_d;
  logic [127:0]   vout_data_q, vout_data_d;
  logic           err_timeout_q, err_timeout_d;
  logic           launch;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      cnt_q           <= '0;
      mm_mul_type_q   <= 1'b0;
      mm_mode_q       <= 1'b0;
      mm_addr_q       <= '0;
      mat_done_q      <= 1'b0;
      mat_done_mode_q <= 1'b0;
      vout_valid_q    <= 1'b0;
      vout_data_q     <= '0;
      err_timeout_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      cnt_q           <= cnt_d;
      mm_mul_type_q   <= mm_mul_type_d;
      mm_mode_q       <= mm_mode_d;
      mm_addr_q       <= mm_addr_d;
      mat_done_q      <= mat_done_d;
      mat_done_mode_q <= mat_done_mode_d;
      vout_valid_q    <= vout_valid_d;
      vout_data_q     <= vout_data_d;
      err_timeout_q   <= err_timeout_d;
    end
  end

  // Next-state logic. The counter is loaded with 1 at launch so that it holds
  // the number of cycles elapsed since the mm_en cycle.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    mm_mul_type_d   = mm_mul_type_q;
    mm_mode_d       = mm_mode_q;
    mm_addr_d       = mm_addr_q;
    mat_done_d      = 1'b0;
    mat_done_mode_d = mat_done_mode_q;
    vout_valid_d    = vout_valid_q;
    vout_data_d     = vout_data_q;
    err_timeout_d   = err_timeout_q;

    // Consumer handshake first, so a same-cycle capture below overrides it.
    if (vout_valid_q && vout_ready) vout_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d       = head.is_mat ? S_MAT_RUN : S_VTX_RUN;
          cnt_d         = CW'(1);
          mm_mul_type_d = head.is_mat;
          mm_mode_d     = head.is_mat & head.mode;
          mm_addr_d     = head.addr;
        end
      end
      S_MAT_RUN: begin
        if (mm_write_en) begin
          mat_done_d      = 1'b1;
          mat_done_mode_d = mm_mode_q;
          state_d         = S_IDLE;
          cnt_d           = '0;
        end else if (cnt_q == CW'(MAT_TIMEOUT)) begin
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_VTX_RUN: begin
        if (cnt_q == CW'(VTX_CYCLES)) begin
          vout_data_d  = mm_vector;
          vout_valid_d = 1'b1;
          state_d      = S_IDLE;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic. mm_en and the operand controls are combinational in the
  // launch cycle so a command reaches the datapath the cycle after it is
  // pushed; afterwards the held registers drive them. A vertex may launch
  // only if the output register is free or is being emptied this cycle.
  always_comb begin
    launch = 1'b0;
    if (state_q == S_IDLE && !fifo_empty)
      launch = head.is_mat || !vout_valid_q || vout_ready;

    pop           = launch;
    mm_en         = launch;
    mm_mul_type   = launch ? head.is_mat                : mm_mul_type_q;
    mm_mode       = launch ? (head.is_mat & head.mode)  : mm_mode_q;
    mm_addr       = launch ? head.addr                  : mm_addr_q;
    busy          = (state_q != S_IDLE) || !fifo_empty;
    mat_done      = mat_done_q;
    mat_done_mode = mat_done_mode_q;
    vout_valid    = vout_valid_q;
    vout_data     = vout_data_q;
    err_timeout   = err_timeout_q;
  end

endmodule

// File: tb/tb_matrix_mul_sched.sv
// -----------------------------------------------------------------------------
// tb_matrix_mul_sched
//
// Directed bench for matrix_mul_sched. A small datapath model answers matrix
// ops with mm_write_en sixteen cycles after mm_en and presents a cycle-tagged
// vector on mm_vector, so the captured vertex identifies the cycle it came
// from. A monitor logs every launch for order and spacing checks.
// -----------------------------------------------------------------------------
module tb_matrix_mul_sched;

  logic         clk;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_type;
  logic         cmd_mode;
  logic [31:0]  cmd_addr;
  logic         mm_en;
  logic         mm_mul_type;
  logic         mm_mode;
  logic [31:0]  mm_addr;
  logic         mm_write_en;
  logic [127:0] mm_vector;
  logic         busy;
  logic         mat_done;
  logic         mat_done_mode;
  logic         vout_valid;
  logic         vout_ready;
  logic [127:0] vout_data;
  logic         err_timeout;

  matrix_mul_sched #(.DEPTH(4), .VTX_CYCLES(8), .MAT_TIMEOUT(31)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_type      (cmd_type),
    .cmd_mode      (cmd_mode),
    .cmd_addr      (cmd_addr),
    .mm_en         (mm_en),
    .mm_mul_type   (mm_mul_type),
    .mm_mode       (mm_mode),
    .mm_addr       (mm_addr),
    .mm_write_en   (mm_write_en),
    .mm_vector     (mm_vector),
    .busy          (busy),
    .mat_done      (mat_done),
    .mat_done_mode (mat_done_mode),
    .vout_valid    (vout_valid),
    .vout_ready    (vout_ready),
    .vout_data     (vout_data),
    .err_timeout   (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Free-running cycle index; during cycle k (after its rising edge) cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] vec_of(input int c);
    logic [31:0] w;
    w = 32'(c);
    return {32'hA5A5_0000 ^ w, w, ~w, (w * 32'd3) + 32'h1234};
  endfunction

  // Datapath model: write-back strobe in C16 of a matrix op unless stalled.
  logic dp_stall = 1'b0;
  logic dp_pend  = 1'b0;
  int   dp_c0    = 0;
  always @(negedge clk) begin
    mm_vector = vec_of(cyc);
    if (reset) begin
      dp_pend     = 1'b0;
      mm_write_en = 1'b0;
    end else begin
      mm_write_en = dp_pend && !dp_stall && (cyc == dp_c0 + 16);
      if (mm_write_en) dp_pend = 1'b0;
      if (mm_en && mm_mul_type) begin
        dp_pend = 1'b1;
        dp_c0   = cyc;
      end
    end
  end

  // Launch / completion monitor.
  bit          lg_type [$];
  logic [31:0] lg_addr [$];
  int          lg_cyc  [$];
  int          n_done   = 0;
  bit          mat_act  = 1'b0;
  bit          addr_bad = 1'b0;
  logic [31:0] mat_addr = '0;
  always @(negedge clk) begin
    if (!reset) begin
      if (mm_en) begin
        lg_type.push_back(mm_mul_type);
        lg_addr.push_back(mm_addr);
        lg_cyc.push_back(cyc);
        if (mm_mul_type) begin
          mat_act  = 1'b1;
          mat_addr = mm_addr;
        end
      end else if (mat_act && mm_addr != mat_addr) begin
        addr_bad = 1'b1;
      end
      if (mat_done) begin
        n_done++;
        mat_act = 1'b0;
      end
    end
  end

  task automatic cyc_step();
    @(posedge clk);
    #1;
  endtask

  // Offers one command for one cycle; acc reports whether it was taken.
  task automatic push(input logic t, input logic m, input logic [31:0] a, output logic acc);
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_mode  = m;
    cmd_addr  = a;
    @(negedge clk);
    acc = cmd_ready;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic acc;
    int   c0, c0b, base, done0;

    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_type   = 1'b0;
    cmd_mode   = 1'b0;
    cmd_addr   = '0;
    vout_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // ---- Reset state ----
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_mm_en", mm_en, 0);
    check("rst_mm_addr", mm_addr, 0);
    check("rst_vout_valid", vout_valid, 0);
    check("rst_err", err_timeout, 0);
    cyc_step();

    // ---- Single vertex ----
    push(1'b0, 1'b1, 32'h40, acc);
    @(negedge clk);
    check("v1_mm_en", mm_en, 1);
    check("v1_type", mm_mul_type, 0);
    check("v1_mode", mm_mode, 0);
    check("v1_addr", mm_addr, 32'h40);
    c0 = cyc;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (vout_valid) break;
    end
    check("v1_latency", cyc - c0, 9);
    check("v1_data", vout_data, vec_of(c0 + 8));
    cyc_step();

    // ---- Matrix op, projection ----
    done0 = n_done;
    push(1'b1, 1'b1, 32'h1000, acc);
    @(negedge clk);
    check("m1_mm_en", mm_en, 1);
    check("m1_type", mm_mul_type, 1);
    check("m1_mode", mm_mode, 1);
    c0 = cyc;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mat_done) break;
    end
    check("m1_latency", cyc - c0, 17);
    check("m1_done_mode", mat_done_mode, 1);
    check("m1_addr_stable", addr_bad, 0);
    check("m1_busy_after", busy, 0);
    cyc_step();
    check("m1_done_count", n_done - done0, 1);

    // ---- Fill FIFO behind a running matrix op, then drain ----
    base  = lg_cyc.size();
    done0 = n_done;
    push(1'b1, 1'b0, 32'h100, acc);
    push(1'b1, 1'b1, 32'h200, acc);
    push(1'b0, 1'b0, 32'h300, acc);
    push(1'b0, 1'b0, 32'h400, acc);
    push(1'b1, 1'b0, 32'h500, acc);
    check("fill_4th_accepted", acc, 1);
    push(1'b1, 1'b0, 32'h600, acc);
    check("fill_5th_rejected", acc, 0);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy && !vout_valid) break;
    end
    cyc_step();
    check("fill_launches", lg_cyc.size() - base, 5);
    if (lg_cyc.size() - base >= 5) begin
      check("fill_order0", {lg_type[base+1], lg_addr[base+1]}, {1'b1, 32'h200});
      check("fill_order1", {lg_type[base+2], lg_addr[base+2]}, {1'b0, 32'h300});
      check("fill_order2", {lg_type[base+3], lg_addr[base+3]}, {1'b0, 32'h400});
      check("fill_order3", {lg_type[base+4], lg_addr[base+4]}, {1'b1, 32'h500});
      check("gap_mat_mat", lg_cyc[base+1] - lg_cyc[base], 17);
      check("gap_mat_vtx", lg_cyc[base+2] - lg_cyc[base+1], 17);
      check("gap_vtx_vtx", lg_cyc[base+3] - lg_cyc[base+2], 9);
      check("gap_vtx_mat", lg_cyc[base+4] - lg_cyc[base+3], 9);
    end
    check("fill_done_count", n_done - done0, 3);

    // ---- Output back-pressure blocks the next vertex ----
    vout_ready = 1'b0;
    base = lg_cyc.size();
    push(1'b0, 1'b0, 32'h700, acc);
    push(1'b0, 1'b0, 32'h800, acc);
    repeat (25) cyc_step();
    check("bp_held_valid", vout_valid, 1);
    check("bp_launches", lg_cyc.size() - base, 1);
    if (lg_cyc.size() > base)
      check("bp_held_data", vout_data, vec_of(lg_cyc[base] + 8));
    check("bp_busy", busy, 1);
    vout_ready = 1'b1;
    @(negedge clk);
    check("bp_release_en", mm_en, 1);
    check("bp_release_addr", mm_addr, 32'h800);
    @(posedge clk);
    #1;
    vout_ready = 1'b0;
    check("bp_valid_cleared", vout_valid, 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (vout_valid) break;
    end
    c0b = (lg_cyc.size() > base + 1) ? lg_cyc[base+1] : 0;
    check("bp_second_latency", cyc - c0b, 9);
    check("bp_second_data", vout_data, vec_of(c0b + 8));
    cyc_step();
    vout_ready = 1'b1;
    cyc_step();
    cyc_step();

    // ---- Matrix timeout ----
    dp_stall = 1'b1;
    done0    = n_done;
    push(1'b1, 1'b1, 32'h900, acc);
    @(negedge clk);
    check("to_mm_en", mm_en, 1);
    c0 = cyc;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (err_timeout) break;
    end
    check("to_latency", cyc - c0, 32);
    check("to_idle", busy, 0);
    cyc_step();
    dp_stall = 1'b0;
    check("to_no_done", n_done - done0, 0);
    push(1'b0, 1'b0, 32'hA00, acc);
    @(negedge clk);
    check("to_next_en", mm_en, 1);
    check("to_next_addr", mm_addr, 32'hA00);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (vout_valid) break;
    end
    check("to_sticky", err_timeout, 1);
    cyc_step();
    cyc_step();

    // ---- Reset in C5 of a vertex with two commands queued ----
    push(1'b0, 1'b0, 32'hB00, acc);
    push(1'b1, 1'b1, 32'hC00, acc);
    c0 = lg_cyc[lg_cyc.size()-1];
    push(1'b0, 1'b0, 32'hD00, acc);
    for (int k = 0; k < 10 && cyc != c0 + 5; k++) cyc_step();
    check("rst_mid_at_c5", cyc - c0, 5);
    reset = 1'b1;
    cyc_step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_mm_en", mm_en, 0);
    check("rst_mid_ctrl", {mm_mul_type, mm_mode, mm_addr}, 34'h0);
    check("rst_mid_done", {mat_done, mat_done_mode}, 2'b00);
    check("rst_mid_vout", {vout_valid, vout_data}, 129'h0);
    check("rst_mid_err", err_timeout, 0);
    check("rst_mid_ready", cmd_ready, 1);
    cyc_step();
    base = lg_cyc.size();
    repeat (20) cyc_step();
    check("rst_mid_no_launch", lg_cyc.size() - base, 0);
    check("rst_mid_no_vout", vout_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
